c17_resp_misr: RTL and testbench

Downstream response compactor for the two-stage pipelined c17 (`c17_s2`). It consumes N22/N23 and uses a delayed copy of the input-valid strobe to align each response with the vector that produced it. It folds a fixed number of responses into a 16-bit MISR signature, then compares the result against a golden value. This gives the bit-level pipelining bench a self-checking pass/fail result instead of waveform inspection.

---
 rtl/c17_resp_misr_if.sv | 35 +++
 rtl/c17_resp_misr.sv | 139 +++++++++++++
 tb/tb_c17_resp_misr.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/c17_resp_misr_if.sv
// ============================================================================
// Module   : c17_resp_misr_if
// Brief    : Control/response bundle between a c17 bench driver and the MISR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface c17_resp_misr_if #(
  parameter int SIG_W = 16,
  parameter int CNT_W = 5
);
  logic             start;
  logic             in_valid;
  logic             N22;
  logic             N23;
  logic [SIG_W-1:0] golden_sig;
  logic             accept;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] vec_count;

  modport master (
    output start, in_valid, N22, N23, golden_sig,
    input  accept, busy, done, pass, signature, vec_count
  );

  modport slave (
    input  start, in_valid, N22, N23, golden_sig,
    output accept, busy, done, pass, signature, vec_count
  );
endinterface

`default_nettype wire

// File: rtl/c17_resp_misr.sv
// ============================================================================
// Module   : c17_resp_misr
// Brief    : Aligns c17 responses to their input strobes and folds them into a
//            16-bit MISR, then compares the final signature against golden.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c17_resp_misr #(
  parameter int          LATENCY = 2,
  parameter int          NUM_VEC = 16,
  parameter int          SIG_W   = 16,
  parameter logic [15:0] POLY    = 16'h1021,
  parameter logic [15:0] SEED    = 16'hFFFF,
  parameter int          CNT_W   = $clog2(NUM_VEC + 1)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  c17_resp_misr_if.slave   bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] c_NUM_VEC = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  logic [1:0]         state_q,     state_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   vec_count_q, vec_count_d;
  logic [SIG_W-1:0]   sig_q,       sig_d;
  logic               pass_q,      pass_d;
  logic [LATENCY-1:0] vpipe_q,     vpipe_d;

  logic               w_active;
  logic               w_accept;
  logic               w_compact;
  logic [SIG_W-1:0]   w_sig_step;
  logic [LATENCY-1:0] w_vpipe_shift;

  assign w_active  = (state_q == c_RUN) || (state_q == c_DRAIN);
  assign w_accept  = bus.in_valid && (state_q == c_RUN) && (issue_cnt_q < c_NUM_VEC);
  assign w_compact = w_active && vpipe_q[LATENCY-1];

  // Galois-style shift with the 2-bit response XORed into the low end.
  assign w_sig_step = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                    ^ {{(SIG_W-2){1'b0}}, bus.N23, bus.N22};

  generate
    if (LATENCY == 1) begin : g_vpipe_single
      assign w_vpipe_shift = w_accept;
    end else begin : g_vpipe_multi
      assign w_vpipe_shift = {vpipe_q[LATENCY-2:0], w_accept};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    vec_count_d = vec_count_q;
    sig_d       = sig_q;
    pass_d      = pass_q;
    vpipe_d     = vpipe_q;

    case (state_q)
      c_IDLE, c_DONE: begin
        // The start edge only initialises; vectors are taken from the next cycle.
        if (bus.start) begin
          state_d     = c_RUN;
          sig_d       = SEED;
          issue_cnt_d = '0;
          vec_count_d = '0;
          vpipe_d     = '0;
          pass_d      = 1'b0;
        end
      end

      c_RUN, c_DRAIN: begin
        vpipe_d = w_vpipe_shift;

        if (w_accept) begin
          issue_cnt_d = issue_cnt_q + c_ONE;
        end

        if (w_compact) begin
          sig_d = w_sig_step;
          if (vec_count_q < c_NUM_VEC) begin
            vec_count_d = vec_count_q + c_ONE;
          end
        end

        if ((state_q == c_RUN) && (issue_cnt_d == c_NUM_VEC)) begin
          state_d = c_DRAIN;
        end

        // Verdict uses the signature being written on this same edge.
        if ((state_q == c_DRAIN) && (vec_count_d == c_NUM_VEC)) begin
          state_d = c_DONE;
          pass_d  = (sig_d == bus.golden_sig);
        end
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_IDLE;
      issue_cnt_q <= '0;
      vec_count_q <= '0;
      sig_q       <= SEED;
      pass_q      <= 1'b0;
      vpipe_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      vec_count_q <= vec_count_d;
      sig_q       <= sig_d;
      pass_q      <= pass_d;
      vpipe_q     <= vpipe_d;
    end
  end

  assign bus.accept    = w_accept;
  assign bus.busy      = w_active;
  assign bus.done      = (state_q == c_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.vec_count = vec_count_q;

endmodule

`default_nettype wire

// File: tb/tb_c17_resp_misr.sv
// ============================================================================
// Module   : tb_c17_resp_misr
// Brief    : Directed bench for c17_resp_misr (NUM_VEC=1 and NUM_VEC=4 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c17_resp_misr;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  c17_resp_misr_if #(.SIG_W(16), .CNT_W(1)) if_a ();
  c17_resp_misr_if #(.SIG_W(16), .CNT_W(3)) if_b ();

  c17_resp_misr #(.LATENCY(2), .NUM_VEC(1), .SIG_W(16), .POLY(16'h1021),
                  .SEED(16'hFFFF), .CNT_W(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  c17_resp_misr #(.LATENCY(2), .NUM_VEC(4), .SIG_W(16), .POLY(16'h1021),
                  .SEED(16'hFFFF), .CNT_W(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    if_a.start = 1'b0; if_a.in_valid = 1'b0; if_a.N22 = 1'b0; if_a.N23 = 1'b0;
    if_a.golden_sig = 16'hEFDC;
    if_b.start = 1'b0; if_b.in_valid = 1'b0; if_b.N22 = 1'b0; if_b.N23 = 1'b0;
    if_b.golden_sig = 16'h0E07;
    rst_n = 1'b1;

    // Asynchronous reset: visible before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sig_a",  if_a.signature, 16'hFFFF);
    chk("rst_busy_a", if_a.busy, 0);
    chk("rst_done_a", if_a.done, 0);
    chk("rst_pass_a", if_a.pass, 0);
    chk("rst_vec_a",  if_a.vec_count, 0);
    chk("rst_sig_b",  if_b.signature, 16'hFFFF);
    tick(); tick();
    rst_n = 1'b1;

    // ---------------- DUT A: NUM_VEC=1 ----------------
    if_a.in_valid = 1'b1;
    #1 chk("idle_ignore_acc", if_a.accept, 0);
    tick();
    chk("idle_ignore_vec", if_a.vec_count, 0);
    chk("idle_ignore_busy", if_a.busy, 0);
    if_a.start = 1'b1;
    #1 chk("start_cycle_acc", if_a.accept, 0);
    tick();                                   // IDLE -> RUN
    if_a.start = 1'b0;
    #1 chk("a1_accept", if_a.accept, 1);
    chk("a1_busy", if_a.busy, 1);
    tick();                                   // accept edge k
    if_a.in_valid = 1'b0;
    #1 chk("a1_drain_acc", if_a.accept, 0);
    chk("a1_drain_busy", if_a.busy, 1);
    tick();                                   // k+1: response not yet due
    chk("a1_k1_vec", if_a.vec_count, 0);
    chk("a1_k1_sig", if_a.signature, 16'hFFFF);
    if_a.N22 = 1'b1; if_a.N23 = 1'b1;
    tick();                                   // k+2: compaction
    if_a.N22 = 1'b0; if_a.N23 = 1'b0;
    chk("a1_sig",  if_a.signature, 16'hEFDC);
    chk("a1_vec",  if_a.vec_count, 1);
    chk("a1_done", if_a.done, 1);
    chk("a1_pass", if_a.pass, 1);
    chk("a1_busy_end", if_a.busy, 0);

    // Restart from DONE with a wrong golden value
    if_a.golden_sig = 16'hEFDF;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    chk("a2_reload_sig", if_a.signature, 16'hFFFF);
    chk("a2_done_low", if_a.done, 0);
    chk("a2_pass_clr", if_a.pass, 0);
    chk("a2_vec_clr", if_a.vec_count, 0);
    if_a.in_valid = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    tick();
    if_a.N22 = 1'b1; if_a.N23 = 1'b1;
    tick();
    if_a.N22 = 1'b0; if_a.N23 = 1'b0;
    chk("a2_sig_repeat", if_a.signature, 16'hEFDC);
    chk("a2_done", if_a.done, 1);
    chk("a2_pass_bad", if_a.pass, 0);

    // ---------------- DUT B: NUM_VEC=4, gapped 1,0,1,1,0,1 ----------------
    if_b.start = 1'b1;
    tick();                                   // RUN
    if_b.start = 1'b0; if_b.in_valid = 1'b1; if_b.N22 = 1'b1; if_b.N23 = 1'b1;
    #1 chk("b_acc1", if_b.accept, 1);
    tick();                                   // accept #1
    if_b.in_valid = 1'b0;
    #1 chk("b_gap1_acc", if_b.accept, 0);
    tick();
    if_b.in_valid = 1'b1; if_b.start = 1'b1;  // start during RUN is ignored
    if_b.N22 = 1'b1; if_b.N23 = 1'b1;         // response 11 for vector 1
    #1 chk("b_acc2", if_b.accept, 1);
    tick();                                   // accept #2, compact #1
    if_b.start = 1'b0;
    chk("b_vec1", if_b.vec_count, 1);
    chk("b_sig1", if_b.signature, 16'hEFDC);
    chk("b_busy_start_ign", if_b.busy, 1);
    tick();                                   // accept #3, bubble in compaction
    chk("b_vec1_hold", if_b.vec_count, 1);
    if_b.in_valid = 1'b0;
    if_b.N22 = 1'b1; if_b.N23 = 1'b0;         // response 01 for vector 2
    tick();                                   // compact #2
    chk("b_vec2", if_b.vec_count, 2);
    chk("b_sig2", if_b.signature, 16'hCF98);
    if_b.in_valid = 1'b1;
    if_b.N22 = 1'b0; if_b.N23 = 1'b1;         // response 10 for vector 3
    #1 chk("b_acc4", if_b.accept, 1);
    tick();                                   // accept #4 -> DRAIN, compact #3
    if_b.N22 = 1'b1; if_b.N23 = 1'b1;         // junk, must not be folded in
    #1 chk("b_overrun_acc", if_b.accept, 0);
    chk("b_vec3", if_b.vec_count, 3);
    chk("b_sig3", if_b.signature, 16'h8F13);
    chk("b_drain_busy", if_b.busy, 1);
    chk("b_drain_done", if_b.done, 0);
    tick();                                   // 1 edge after last accept
    chk("b_not_done_yet", if_b.done, 0);
    chk("b_vec3_hold", if_b.vec_count, 3);
    if_b.N22 = 1'b0; if_b.N23 = 1'b0;         // response 00 for vector 4
    tick();                                   // 2 edges after last accept
    chk("b_done", if_b.done, 1);
    chk("b_pass", if_b.pass, 1);
    chk("b_vec4", if_b.vec_count, 4);
    chk("b_sig4", if_b.signature, 16'h0E07);
    chk("b_done_busy", if_b.busy, 0);
    chk("b_done_acc", if_b.accept, 0);
    tick();
    chk("b_done_sig_hold", if_b.signature, 16'h0E07);
    chk("b_done_vec_hold", if_b.vec_count, 4);
    chk("b_done_hold", if_b.done, 1);

    // ---------------- Abort in DRAIN ----------------
    if_b.in_valid = 1'b0;
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    chk("b_restart_sig", if_b.signature, 16'hFFFF);
    if_b.in_valid = 1'b1; if_b.N22 = 1'b1; if_b.N23 = 1'b1;
    tick(); tick(); tick(); tick();
    if_b.in_valid = 1'b0;
    chk("b_abort_busy_pre", if_b.busy, 1);
    chk("b_abort_acc_pre", if_b.accept, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", if_b.busy, 0);
    chk("abort_done", if_b.done, 0);
    chk("abort_pass", if_b.pass, 0);
    chk("abort_sig",  if_b.signature, 16'hFFFF);
    chk("abort_vec",  if_b.vec_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_idle_busy", if_b.busy, 0);
    chk("abort_idle_done", if_b.done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
